// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks in-flight destinations, drives stall and operand bypass selects.
// Latency: stall/issue/fwd_sel are combinational from slot state; slots advance one stage per cycle.
// Backpressure: stall holds PC/IF/ID and injects a bubble into EXE; flush drops ID and the youngest slots.
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int WB_STAGE   = 3,
    parameter int SEL_W      = 2,
    parameter int FWD_EN     = 1,
    parameter int FLUSH_AGE  = 1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] rs1,
    input  logic [REG_ADDR_W-1:0] rs2,
    input  logic                  rs1_used,
    input  logic                  rs2_used,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  rd_valid,
    input  logic [SEL_W-1:0]      lat,
    input  logic                  flush,
    output logic                  stall,
    output logic                  issue,
    output logic [SEL_W-1:0]      fwd_sel1,
    output logic [SEL_W-1:0]      fwd_sel2,
    output logic [CNT_W-1:0]      stall_count
);

    localparam logic [SEL_W-1:0] WB_SEL = SEL_W'(WB_STAGE);

    logic [WB_STAGE:1]     slot_v;
    logic [REG_ADDR_W-1:0] slot_rd  [1:WB_STAGE];
    logic [SEL_W-1:0]      slot_lat [1:WB_STAGE];

    logic             hit1, hit2, haz1, haz2;
    logic [SEL_W-1:0] m1, m2, ml1, ml2, lat_n;

    // Scan oldest to youngest so the youngest matching producer is the one that sticks (WAW).
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        m1   = '0;
        m2   = '0;
        ml1  = '0;
        ml2  = '0;
        for (int k = WB_STAGE; k >= 1; k--) begin
            if (slot_v[k] && slot_rd[k] == rs1) begin
                hit1 = 1'b1;
                m1   = SEL_W'(k);
                ml1  = slot_lat[k];
            end
            if (slot_v[k] && slot_rd[k] == rs2) begin
                hit2 = 1'b1;
                m2   = SEL_W'(k);
                ml2  = slot_lat[k];
            end
        end
        hit1 = hit1 & rs1_used & (rs1 != '0);
        hit2 = hit2 & rs2_used & (rs2 != '0);
        if (FWD_EN != 0) begin
            haz1 = hit1 && (m1 < ml1);
            haz2 = hit2 && (m2 < ml2);
        end else begin
            haz1 = hit1 && (m1 < WB_SEL);
            haz2 = hit2 && (m2 < WB_SEL);
        end
        fwd_sel1 = (FWD_EN != 0 && hit1 && !haz1) ? m1 : '0;
        fwd_sel2 = (FWD_EN != 0 && hit2 && !haz2) ? m2 : '0;
    end

    always_comb begin
        if (lat == '0)
            lat_n = SEL_W'(1);
        else if (lat > WB_SEL)
            lat_n = WB_SEL;
        else
            lat_n = lat;
    end

    assign stall = id_valid & ~flush & (haz1 | haz2);
    assign issue = id_valid & ~stall & ~flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_v      <= '0;
            stall_count <= '0;
        end else begin
            slot_v[1] <= issue & rd_valid & (rd != '0);
            // Flush kills the youngest FLUSH_AGE in-flight slots; older ones retire normally.
            for (int k = 2; k <= WB_STAGE; k++)
                slot_v[k] <= slot_v[k-1] & ~(flush && (k - 1 <= FLUSH_AGE));
            if (stall && stall_count != '1)
                stall_count <= stall_count + CNT_W'(1);
        end
    end

    // Payload is qualified by slot_v, so it needs no reset.
    always_ff @(posedge clk) begin
        slot_rd[1]  <= rd;
        slot_lat[1] <= lat_n;
        for (int k = 2; k <= WB_STAGE; k++) begin
            slot_rd[k]  <= slot_rd[k-1];
            slot_lat[k] <= slot_lat[k-1];
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: forwarding instance plus a no-bypass instance with a 2-bit stall counter.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, rs1_used, rs2_used, rd_valid, flush;
    logic [4:0] rs1, rs2, rd;
    logic [1:0] lat;

    logic        stall0, issue0, stall1, issue1;
    logic [1:0]  sel1_0, sel2_0, sel1_1, sel2_1;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        which;
        logic        stall;
        logic        issue;
        logic [1:0]  sel1;
        logic [1:0]  sel2;
        logic [15:0] cnt;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [15:0] exp_cnt0;
    logic [1:0]  exp_cnt1;

    always #5 clk = ~clk;

    hazard_scoreboard dut0 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .rs1(rs1), .rs2(rs2),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .rd(rd), .rd_valid(rd_valid),
        .lat(lat), .flush(flush), .stall(stall0), .issue(issue0),
        .fwd_sel1(sel1_0), .fwd_sel2(sel2_0), .stall_count(cnt0)
    );

    hazard_scoreboard #(.FWD_EN(0), .CNT_W(2)) dut1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .rs1(rs1), .rs2(rs2),
        .rs1_used(rs1_used), .rs2_used(rs2_used), .rd(rd), .rd_valid(rd_valid),
        .lat(lat), .flush(flush), .stall(stall1), .issue(issue1),
        .fwd_sel1(sel1_1), .fwd_sel2(sel2_1), .stall_count(cnt1)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one expected record per driven cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.which == 1'b0) begin
                cmp("fwd.stall", {31'd0, stall0}, {31'd0, e.stall});
                cmp("fwd.issue", {31'd0, issue0}, {31'd0, e.issue});
                cmp("fwd.sel1",  {30'd0, sel1_0}, {30'd0, e.sel1});
                cmp("fwd.sel2",  {30'd0, sel2_0}, {30'd0, e.sel2});
                cmp("fwd.count", {16'd0, cnt0},   {16'd0, e.cnt});
            end else begin
                cmp("nofwd.stall", {31'd0, stall1}, {31'd0, e.stall});
                cmp("nofwd.issue", {31'd0, issue1}, {31'd0, e.issue});
                cmp("nofwd.sel1",  {30'd0, sel1_1}, {30'd0, e.sel1});
                cmp("nofwd.sel2",  {30'd0, sel2_1}, {30'd0, e.sel2});
                cmp("nofwd.count", {30'd0, cnt1},   {16'd0, e.cnt});
            end
        end
    end

    // Drive one cycle of inputs and queue the hand-computed response.
    task automatic cyc(input logic iv, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2,
                       input logic [4:0] rdd, input logic rdv, input logic [1:0] lt,
                       input logic fl, input logic w,
                       input logic es, input logic [1:0] s1, input logic [1:0] s2);
        exp_t x;
        id_valid = iv; rs1 = r1; rs1_used = u1; rs2 = r2; rs2_used = u2;
        rd = rdd; rd_valid = rdv; lat = lt; flush = fl;
        x.which = w;
        x.stall = es;
        x.issue = iv & ~es & ~fl;
        x.sel1  = s1;
        x.sel2  = s2;
        x.cnt   = w ? {14'd0, exp_cnt1} : exp_cnt0;
        if (es) begin
            if (w) begin
                if (exp_cnt1 != 2'd3) exp_cnt1 = exp_cnt1 + 2'd1;
            end else begin
                exp_cnt0 = exp_cnt0 + 16'd1;
            end
        end
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; rs1 = 0; rs1_used = 0; rs2 = 0; rs2_used = 0;
        rd = 0; rd_valid = 0; lat = 0; flush = 0;
    endtask

    task automatic rst_dut();
        idle_inputs();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_cnt0 = '0;
        exp_cnt1 = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        idle_inputs();
        reset = 1'b1;
        exp_cnt0 = '0;
        exp_cnt1 = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state: lone consumer issues with no hazard; then ALU chain rd=5 lat=1.
        cyc(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 2'd1, 0, 0, 0, 2'd0, 2'd0);
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 2'd1, 0, 0, 0, 2'd0, 2'd0);
        cyc(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 2'd0, 0, 0, 0, 2'd1, 2'd0);
        cyc(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 2'd0, 0, 0, 0, 2'd2, 2'd0);
        cyc(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 2'd0, 0, 0, 0, 2'd3, 2'd0);
        cyc(1, 5'd5, 1, 5'd0, 0, 5'd0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd0);

        // Load-use on rs2: one stall, then bypass from stage 2.
        rst_dut();
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 2'd2, 0, 0, 0, 2'd0, 2'd0);
        cyc(1, 5'd0, 0, 5'd7, 1, 5'd0, 0, 2'd0, 0, 0, 1, 2'd0, 2'd0);
        cyc(1, 5'd0, 0, 5'd7, 1, 5'd0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd2);
        cyc(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd0);

        // x0 destination/source, unused operand behind a load, lat=0 treated as 1.
        rst_dut();
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd0, 1, 2'd1, 0, 0, 0, 2'd0, 2'd0);
        cyc(1, 5'd0, 1, 5'd0, 0, 5'd0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd0);
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd5, 1, 2'd2, 0, 0, 0, 2'd0, 2'd0);
        cyc(1, 5'd0, 0, 5'd5, 0, 5'd0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd0);
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd6, 1, 2'd0, 0, 0, 0, 2'd0, 2'd0);
        cyc(1, 5'd6, 1, 5'd0, 0, 5'd0, 0, 2'd0, 0, 0, 0, 2'd1, 2'd0);

        // WAW + flush: younger rd=4 killed, older load to 4 seen at slot 3.
        rst_dut();
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd4, 1, 2'd2, 0, 0, 0, 2'd0, 2'd0);
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd4, 1, 2'd1, 0, 0, 0, 2'd0, 2'd0);
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd4, 1, 2'd1, 1, 0, 0, 2'd0, 2'd0);
        cyc(1, 5'd4, 1, 5'd0, 0, 5'd0, 0, 2'd0, 0, 0, 0, 2'd3, 2'd0);
        cyc(1, 5'd4, 1, 5'd0, 0, 5'd0, 0, 2'd0, 0, 0, 0, 2'd0, 2'd0);

        // No bypass: wait for slot 3 twice; the 2-bit counter saturates at 3.
        rst_dut();
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd3, 1, 2'd1, 0, 1, 0, 2'd0, 2'd0);
        cyc(1, 5'd3, 1, 5'd0, 0, 5'd3, 1, 2'd1, 0, 1, 1, 2'd0, 2'd0);
        cyc(1, 5'd3, 1, 5'd0, 0, 5'd3, 1, 2'd1, 0, 1, 1, 2'd0, 2'd0);
        cyc(1, 5'd3, 1, 5'd0, 0, 5'd3, 1, 2'd1, 0, 1, 0, 2'd0, 2'd0);
        cyc(1, 5'd3, 1, 5'd0, 0, 5'd3, 1, 2'd1, 0, 1, 1, 2'd0, 2'd0);
        cyc(1, 5'd3, 1, 5'd0, 0, 5'd3, 1, 2'd1, 0, 1, 1, 2'd0, 2'd0);
        cyc(1, 5'd3, 1, 5'd0, 0, 5'd3, 1, 2'd1, 0, 1, 0, 2'd0, 2'd0);
        cyc(0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 2'd0, 0, 1, 0, 2'd0, 2'd0);

        // Asynchronous reset while a consumer waits on a lat=3 producer.
        rst_dut();
        cyc(1, 5'd0, 0, 5'd0, 0, 5'd7, 1, 2'd3, 0, 0, 0, 2'd0, 2'd0);
        cyc(1, 5'd0, 0, 5'd7, 1, 5'd0, 0, 2'd0, 0, 0, 1, 2'd0, 2'd0);
        #1;
        cmp("arst.pre_stall", {31'd0, stall0}, 32'd1);
        cmp("arst.pre_count", {16'd0, cnt0},   32'd1);
        reset = 1'b1;
        #1;
        cmp("arst.stall", {31'd0, stall0}, 32'd0);
        cmp("arst.count", {16'd0, cnt0},   32'd0);
        cmp("arst.issue", {31'd0, issue0}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_inputs();

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            bad++;
            total++;
            $display("FAIL drain: %0d records unchecked, expected 0", q.size());
        end
        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
